// File: rtl/spi_sensor_poller.sv
// SPI mode-3 master that writes one configuration register after reset, then
// burst-reads NUM_CH channels per frame into a double-buffered sample register.
module spi_sensor_poller #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned NUM_CH     = 6,
  parameter int unsigned CH_W       = 16,
  parameter logic [7:0]  CFG_ADDR   = 8'h10,
  parameter logic [7:0]  CFG_VAL    = 8'h60,
  parameter logic [7:0]  DATA_ADDR  = 8'h22,
  parameter int unsigned CONTINUOUS = 1,
  parameter int unsigned GAP        = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     SDO,
  output logic                     CS,
  output logic                     SPC,
  output logic                     SDI,
  output logic [NUM_CH*CH_W-1:0]   curr_data,
  output logic                     valid,
  output logic                     busy,
  output logic                     missed
);
  localparam int unsigned DATA_W   = NUM_CH * CH_W;
  localparam int unsigned CFG_BITS = 16;
  localparam int unsigned RD_BITS  = 8 + DATA_W;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HP_W     = $clog2(2 * RD_BITS + 1);
  localparam int unsigned GAP_W    = $clog2(GAP);
  localparam int unsigned NBYTES   = DATA_W / 8;
  localparam int unsigned BPC      = CH_W / 8;

  typedef enum logic [1:0] {CFG_WR, GAP_WAIT, IDLE, RD_FRAME} state_e;

  state_e              state_q, state_d;
  logic                cs_q, cs_d, spc_q, spc_d, sdi_q, sdi_d;
  logic                valid_q, valid_d, end_q, end_d, missed_q, missed_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [HP_W-1:0]     hp_q, hp_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [15:0]         tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d, data_q, data_d, rx_ordered;
  logic                in_frame, tick, last_hp, frame_done, gap_done, start_rd;

  // hp_q counts SPC half-periods since CS fell: odd = SPC low, even = SPC high.
  assign in_frame   = (state_q == CFG_WR || state_q == RD_FRAME) && !cs_q;
  assign tick       = div_q == DIV_W'(CLK_DIV - 1);
  assign last_hp    = hp_q == ((state_q == CFG_WR) ? HP_W'(2 * CFG_BITS) : HP_W'(2 * RD_BITS));
  assign frame_done = in_frame && tick && last_hp;
  assign gap_done   = (state_q == GAP_WAIT) && (gap_q == GAP_W'(GAP - 1));
  assign start_rd   = (gap_done && CONTINUOUS != 0) || (state_q == IDLE && req);

  // Bytes arrive low byte first per channel; rx_q holds them in arrival order.
  always_comb begin
    rx_ordered = '0;
    for (int unsigned c = 0; c < NUM_CH; c++)
      for (int unsigned k = 0; k < BPC; k++)
        rx_ordered[(NUM_CH-1-c)*CH_W + k*8 +: 8] = rx_q[(NBYTES-1-(c*BPC+k))*8 +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= CFG_WR;
      cs_q     <= 1'b1;
      spc_q    <= 1'b1;
      sdi_q    <= 1'b0;
      valid_q  <= 1'b0;
      end_q    <= 1'b0;
      missed_q <= 1'b0;
      div_q    <= '0;
      hp_q     <= '0;
      gap_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cs_q     <= cs_d;
      spc_q    <= spc_d;
      sdi_q    <= sdi_d;
      valid_q  <= valid_d;
      end_q    <= end_d;
      missed_q <= missed_d;
      div_q    <= div_d;
      hp_q     <= hp_d;
      gap_q    <= gap_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CFG_WR:   if (frame_done) state_d = GAP_WAIT;
      GAP_WAIT: if (gap_done) state_d = (CONTINUOUS != 0) ? RD_FRAME : IDLE;
      IDLE:     if (req) state_d = RD_FRAME;
      RD_FRAME: if (frame_done) state_d = GAP_WAIT;
      default:  state_d = CFG_WR;
    endcase
  end

  always_comb begin
    cs_d     = cs_q;
    spc_d    = spc_q;
    sdi_d    = sdi_q;
    valid_d  = 1'b0;
    end_d    = 1'b0;
    missed_d = missed_q | (req && (CONTINUOUS == 0) && (state_q != IDLE));
    div_d    = div_q;
    hp_d     = hp_q;
    gap_d    = gap_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    data_d   = data_q;
    if (start_rd) begin
      cs_d = 1'b0;
      div_d = '0;
      hp_d = '0;
      tx_d = {1'b1, DATA_ADDR[6:0], 8'h00};
    end else if (state_q == CFG_WR && cs_q) begin
      cs_d = 1'b0;
      div_d = '0;
      hp_d = '0;
      tx_d = {1'b0, CFG_ADDR[6:0], CFG_VAL};
    end else if (in_frame) begin
      if (!tick) begin
        div_d = div_q + 1'b1;
      end else begin
        div_d = '0;
        if (last_hp) begin
          cs_d  = 1'b1;
          spc_d = 1'b1;
          sdi_d = 1'b0;
          end_d = 1'b1;
          gap_d = '0;
          if (state_q == RD_FRAME) begin
            valid_d = 1'b1;
            data_d  = rx_ordered;
          end
        end else begin
          hp_d = hp_q + 1'b1;
          if (!hp_q[0]) begin
            spc_d = 1'b0;
            sdi_d = tx_q[15];
            tx_d  = {tx_q[14:0], 1'b0};
          end else begin
            spc_d = 1'b1;
            if (state_q == RD_FRAME) rx_d = {rx_q[DATA_W-2:0], SDO};
          end
        end
      end
    end else if (state_q == GAP_WAIT) begin
      gap_d = gap_done ? '0 : gap_q + 1'b1;
    end
  end

  assign CS        = cs_q;
  assign SPC       = spc_q;
  assign SDI       = sdi_q;
  assign curr_data = data_q;
  assign valid     = valid_q;
  assign busy      = !cs_q || end_q;
  assign missed    = missed_q;

endmodule

// File: tb/tb_spi_sensor_poller.sv
// Bench for spi_sensor_poller: default free-running instance plus a small
// request-driven instance, each talking to a behavioural SPI slave.
module tb_spi_sensor_poller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, req_a, req_b;
  logic sdo_a = 1'b0, sdo_b = 1'b0;
  logic CS_a, SPC_a, SDI_a, valid_a, busy_a, missed_a;
  logic CS_b, SPC_b, SDI_b, valid_b, busy_b, missed_b;
  logic [95:0] curr_a;
  logic [23:0] curr_b;

  spi_sensor_poller u_a (
    .clk(clk), .reset(rst_a), .req(req_a), .SDO(sdo_a), .CS(CS_a), .SPC(SPC_a), .SDI(SDI_a),
    .curr_data(curr_a), .valid(valid_a), .busy(busy_a), .missed(missed_a)
  );

  spi_sensor_poller #(.CLK_DIV(1), .NUM_CH(3), .CH_W(8), .CONTINUOUS(0), .GAP(4)) u_b (
    .clk(clk), .reset(rst_b), .req(req_b), .SDO(sdo_b), .CS(CS_b), .SPC(SPC_b), .SDI(SDI_b),
    .curr_data(curr_b), .valid(valid_b), .busy(busy_b), .missed(missed_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected sample from the byte stream the slave sends (first byte in the MSBs).
  function automatic logic [95:0] model(input logic [95:0] stream, input int nch, input int chw);
    int nb = nch * chw / 8;
    int bpc = chw / 8;
    logic [95:0] r = '0;
    for (int c = 0; c < nch; c++) begin
      logic [95:0] ch = '0;
      for (int j = 0; j < bpc; j++)
        ch |= 96'(stream[8*(nb-1-(c*bpc+j)) +: 8]) << (8*j);
      r = (r << chw) | ch;
    end
    return r;
  endfunction

  // Slave models and frame monitors, sampled on the falling clock edge.
  logic [95:0]  cur_bytes_a = '0;
  logic [23:0]  cur_bytes_b = '0;
  logic [127:0] sdi_a = '0, sdi_b = '0;
  int rises_a = 0, rises_b = 0, sbit_a = 0, sbit_b = 0, vcount_a = 0, vcount_b = 0;
  logic cs_pa = 1'b1, spc_pa = 1'b1, cs_pb = 1'b1, spc_pb = 1'b1;

  always @(negedge clk) begin
    if (cs_pa && !CS_a) begin rises_a = 0; sdi_a = '0; sbit_a = 0; sdo_a = 1'b0; end
    if (!CS_a && !spc_pa && SPC_a) begin rises_a++; sdi_a = {sdi_a[126:0], SDI_a}; end
    if (!CS_a && spc_pa && !SPC_a) begin
      sdo_a = (sbit_a >= 8 && sbit_a < 104) ? cur_bytes_a[95-(sbit_a-8)] : 1'b0;
      sbit_a++;
    end
    if (valid_a) vcount_a++;
    cs_pa = CS_a;
    spc_pa = SPC_a;
  end

  always @(negedge clk) begin
    if (cs_pb && !CS_b) begin rises_b = 0; sdi_b = '0; sbit_b = 0; sdo_b = 1'b0; end
    if (!CS_b && !spc_pb && SPC_b) begin rises_b++; sdi_b = {sdi_b[126:0], SDI_b}; end
    if (!CS_b && spc_pb && !SPC_b) begin
      sdo_b = (sbit_b >= 8 && sbit_b < 32) ? cur_bytes_b[23-(sbit_b-8)] : 1'b0;
      sbit_b++;
    end
    if (valid_b) vcount_b++;
    cs_pb = CS_b;
    spc_pb = SPC_b;
  end

  // Free-running instance must ignore req entirely.
  initial begin
    req_a = 1'b0;
    forever begin
      @(negedge clk);
      req_a = ($urandom_range(0, 9) == 0);
    end
  end

  task automatic wait_cs(input bit w, input logic lvl, output int n);
    n = 0;
    while ((w ? CS_b : CS_a) !== lvl && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if ((w ? CS_b : CS_a) !== lvl) begin
      checks++;
      errors++;
      $display("FAIL cs_timeout: CS never reached %0b", lvl);
    end
  endtask

  // Entered on the first negedge with CS low; returns on the negedge CS is seen high.
  task automatic frame_checks(input bit w, input logic [95:0] prev, input logic [95:0] exp,
                              input int nbits, input int div, input logic [127:0] sdi_exp,
                              input int req_at);
    int low = 0;
    while ((w ? CS_b : CS_a) === 1'b0 && low < 2000) begin
      low++;
      if (low == nbits) begin
        check("mid_frame_data_held", w ? 128'(curr_b) : 128'(curr_a), 128'(prev));
        check("mid_frame_busy", w ? 128'(busy_b) : 128'(busy_a), 128'd1);
      end
      if (w) req_b = (low == req_at);
      @(negedge clk);
    end
    if (w) req_b = 1'b0;
    check("frame_len", 128'(low), 128'((2*nbits+1)*div));
    check("spc_rises", w ? 128'(rises_b) : 128'(rises_a), 128'(nbits));
    check("sdi_bits", w ? sdi_b : sdi_a, sdi_exp);
    check("valid_at_cs_rise", w ? 128'(valid_b) : 128'(valid_a), 128'd1);
    check("curr_data", w ? 128'(curr_b) : 128'(curr_a), 128'(exp));
    check("busy_at_cs_rise", w ? 128'(busy_b) : 128'(busy_a), 128'd1);
  endtask

  typedef struct {
    logic [95:0] bytes;
    logic [95:0] exp;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int n, k, vc, d, lows;
    logic [95:0] prev, exp;
    rst_a = 1'b1;
    rst_b = 1'b1;
    req_b = 1'b0;
    tbl[0] = '{96'h0102030405060708090A0B0C, 96'h0201_0403_0605_0807_0A09_0C0B};
    tbl[1] = '{{12{8'hFF}}, {96{1'b1}}};
    tbl[2] = '{{6{16'h00FF}}, {6{16'hFF00}}};
    tbl[3] = '{96'h123456789ABCDEF00FEDCBA9, 96'h3412_7856_BC9A_F0DE_ED0F_A9CB};
    for (int i = 4; i < 6; i++) begin
      tbl[i].bytes = {$urandom(), $urandom(), $urandom()};
      tbl[i].exp = model(tbl[i].bytes, 6, 16);
    end

    // ---- default instance: reset state, config write, free-running reads
    repeat (3) @(negedge clk);
    check("rst_cs", 128'(CS_a), 128'd1);
    check("rst_spc", 128'(SPC_a), 128'd1);
    check("rst_sdi", 128'(SDI_a), 128'd0);
    check("rst_valid", 128'(valid_a), 128'd0);
    check("rst_busy", 128'(busy_a), 128'd0);
    check("rst_data", 128'(curr_a), 128'd0);
    rst_a = 1'b0;
    @(negedge clk);
    check("cfg_cs_first_edge", 128'(CS_a), 128'd0);
    wait_cs(1'b0, 1'b1, n);
    check("cfg_rises", 128'(rises_a), 128'd16);
    check("cfg_sdi", sdi_a, 128'h1060);
    check("cfg_no_valid", 128'(valid_a), 128'd0);
    check("cfg_vcount", 128'(vcount_a), 128'd0);
    @(negedge clk);
    prev = '0;
    for (int i = 0; i < 6; i++) begin
      cur_bytes_a = tbl[i].bytes;
      wait_cs(1'b0, 1'b0, n);
      check("gap_len", 128'(n + 1), 128'd16);
      frame_checks(1'b0, prev, tbl[i].exp, 104, 2, 128'hA2 << 96, -1);
      @(negedge clk);
      check("valid_one_cycle", 128'(valid_a), 128'd0);
      check("busy_low_in_gap", 128'(busy_a), 128'd0);
      prev = tbl[i].exp;
    end
    check("valid_count", 128'(vcount_a), 128'd6);
    check("req_ignored_continuous", 128'(missed_a), 128'd0);

    // ---- reset around bit 50 of a read frame
    wait_cs(1'b0, 1'b0, n);
    @(negedge clk);
    k = 0;
    while (rises_a < 50 && k < 1000) begin k++; @(negedge clk); end
    vc = vcount_a;
    rst_a = 1'b1;
    #1;
    check("midrst_cs", 128'(CS_a), 128'd1);
    check("midrst_spc", 128'(SPC_a), 128'd1);
    check("midrst_sdi", 128'(SDI_a), 128'd0);
    check("midrst_data", 128'(curr_a), 128'd0);
    check("midrst_valid", 128'(valid_a), 128'd0);
    check("midrst_busy", 128'(busy_a), 128'd0);
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    check("midrst_cfg_restart", 128'(CS_a), 128'd0);
    wait_cs(1'b0, 1'b1, n);
    check("midrst_cfg_rises", 128'(rises_a), 128'd16);
    check("midrst_cfg_sdi", sdi_a, 128'h1060);
    check("midrst_no_valid", 128'(vcount_a), 128'(vc));
    rst_a = 1'b1;

    // ---- request-driven small instance
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    check("b_cfg_cs_first_edge", 128'(CS_b), 128'd0);
    wait_cs(1'b1, 1'b1, n);
    check("b_cfg_rises", 128'(rises_b), 128'd16);
    check("b_cfg_sdi", sdi_b, 128'h1060);
    check("b_cfg_no_valid", 128'(valid_b), 128'd0);
    lows = 0;
    repeat (30) begin @(negedge clk); if (!CS_b) lows++; end
    check("b_no_autopoll", 128'(lows), 128'd0);
    check("b_missed_idle", 128'(missed_b), 128'd0);
    prev = '0;
    for (int i = 0; i < 5; i++) begin
      cur_bytes_b = 24'($urandom());
      exp = model(96'(cur_bytes_b), 3, 8);
      d = (i == 1) ? 3 : $urandom_range(3, 8);
      repeat (d) @(negedge clk);
      req_b = 1'b1;
      @(negedge clk);
      req_b = 1'b0;
      check("b_req_start", 128'(CS_b), 128'd0);
      frame_checks(1'b1, prev, exp, 32, 1, 128'hA2 << 24, -1);
      check("b_req_not_missed", 128'(missed_b), 128'd0);
      @(negedge clk);
      check("b_valid_one_cycle", 128'(valid_b), 128'd0);
      prev = exp;
    end

    // ---- req during a frame: flagged, frame completes, nothing queued
    cur_bytes_b = 24'($urandom());
    exp = model(96'(cur_bytes_b), 3, 8);
    repeat (3) @(negedge clk);
    req_b = 1'b1;
    @(negedge clk);
    req_b = 1'b0;
    check("b_req2_start", 128'(CS_b), 128'd0);
    frame_checks(1'b1, prev, exp, 32, 1, 128'hA2 << 24, 10);
    check("b_missed_set", 128'(missed_b), 128'd1);
    lows = 0;
    repeat (40) begin @(negedge clk); if (!CS_b) lows++; end
    check("b_no_second_frame", 128'(lows), 128'd0);
    check("b_missed_sticky", 128'(missed_b), 128'd1);
    check("b_valid_total", 128'(vcount_b), 128'd6);
    rst_b = 1'b1;
    #1;
    check("b_rst_clears_missed", 128'(missed_b), 128'd0);
    check("b_rst_clears_data", 128'(curr_b), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
